// File: rtl/matrix_glyph_scheduler_pkg.sv
// matrix_pkg: shared state encoding and matrix geometry for the glyph scheduler.
package matrix_pkg;
    typedef enum logic {IDLE, SCAN} state_t;
    localparam int ROW_W = 16;
    localparam int COL_W = 4;
    localparam logic [ROW_W-1:0] BLANK_ROW = 16'hFFFF;
endpackage

// File: rtl/matrix_glyph_scheduler_glyph_queue.sv
// glyph_queue: append-only message register file with random read and synchronous clear.
module glyph_queue #(
    parameter int GLYPH_W = 4,
    parameter int QDEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic                      clear,
    input  logic [GLYPH_W-1:0]        wdata,
    input  logic [$clog2(QDEPTH)-1:0] raddr,
    output logic [GLYPH_W-1:0]        rdata,
    output logic [$clog2(QDEPTH):0]   count
);
    logic [GLYPH_W-1:0] mem [QDEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (wr) count <= count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr && !clear) mem[count[$clog2(QDEPTH)-1:0]] <= wdata;
    end
endmodule

// File: rtl/matrix_glyph_scheduler.sv
// matrix_glyph_scheduler: queues glyph indices and scans them onto a 16x16 LED matrix via a font ROM.
// MATRIX_SCROLL_EN selects horizontal scrolling instead of whole-glyph stepping.
module matrix_glyph_scheduler
    import matrix_pkg::*;
#(
    parameter int GLYPH_W      = 4,
    parameter int QDEPTH       = 8,
    parameter int DWELL_FRAMES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [GLYPH_W-1:0] msg_glyph,
    input  logic               clear,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    output logic               busy,
    output logic               done,
    output logic [GLYPH_W-1:0] rom_glyph,
    output logic [COL_W-1:0]   rom_col,
    input  logic [ROW_W-1:0]   rom_row,
    output logic [COL_W-1:0]   keyc,
    output logic [ROW_W-1:0]   keyr
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int FW = DWELL_FRAMES > 1 ? $clog2(DWELL_FRAMES) : 1;

    state_t             state, nxt;
    logic               done_nxt, wr, last, dwell_end, step, scan, live;
    logic               v1, blank_src, rom_blank;
    logic [CW-1:0]      count;
    logic [PW-1:0]      ptr, raddr;
    logic [FW-1:0]      frame;
    logic [COL_W-1:0]   col, gcol, dcol;
    logic [GLYPH_W-1:0] qdata;

    glyph_queue #(.GLYPH_W(GLYPH_W), .QDEPTH(QDEPTH)) u_queue (
        .clk(clk),
        .rst_n(rst_n),
        .wr(wr),
        .clear(clear && !scan),
        .wdata(msg_glyph),
        .raddr(raddr),
        .rdata(qdata),
        .count(count)
    );

    assign scan      = state == SCAN;
    assign busy      = scan;
    assign msg_ready = !scan && count < CW'(QDEPTH);
    assign wr        = msg_valid && msg_ready && !clear;
    assign last      = CW'(ptr) == count - CW'(1);
    assign dwell_end = col == '1 && frame == FW'(DWELL_FRAMES - 1);
    // Pins are blanked on the same edge the scan ends, so keyr is never lit while IDLE.
    assign live      = v1 && nxt == SCAN;

`ifdef MATRIX_SCROLL_EN
    logic [COL_W-1:0] offset;
    logic [COL_W:0]   gsum;
    assign gsum      = {1'b0, offset} + {1'b0, col};
    assign gcol      = gsum[COL_W-1:0];
    assign step      = dwell_end && offset == '1;
    assign raddr     = !gsum[COL_W] ? ptr : last ? '0 : ptr + 1'b1;
    assign blank_src = gsum[COL_W] && last && !loop_en;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) offset <= '0;
        else offset <= !scan ? '0 : dwell_end ? offset + 1'b1 : offset;
    end
`else
    assign gcol      = col;
    assign step      = dwell_end;
    assign raddr     = ptr;
    assign blank_src = 1'b0;
`endif

    always_comb begin
        nxt      = state;
        done_nxt = 1'b0;
        if (!scan) nxt = start && !stop && (wr || (count != '0 && !clear)) ? SCAN : IDLE;
        else if (stop) nxt = IDLE;
        else if (step && last && !loop_en) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            ptr       <= '0;
            col       <= '0;
            frame     <= '0;
            v1        <= 1'b0;
            rom_blank <= 1'b0;
            rom_glyph <= '0;
            rom_col   <= '0;
            dcol      <= '0;
            keyc      <= '0;
            keyr      <= BLANK_ROW;
        end else begin
            state     <= nxt;
            done      <= done_nxt;
            col       <= scan ? col + 1'b1 : '0;
            frame     <= !scan ? '0 : col != '1 ? frame : dwell_end ? '0 : frame + 1'b1;
            ptr       <= !scan ? '0 : !step ? ptr : last ? '0 : ptr + 1'b1;
            v1        <= scan;
            rom_blank <= scan && blank_src;
            rom_glyph <= scan ? qdata : '0;
            rom_col   <= scan ? gcol : '0;
            dcol      <= scan ? col : '0;
            keyc      <= live ? dcol : '0;
            keyr      <= live && !rom_blank ? rom_row : BLANK_ROW;
        end
    end
endmodule
